// File: rtl/trace_stream_arbiter.sv
// Round-robin, packet-atomic arbiter merging NUM_SRC AXI-Stream trace sources into one sink.
// Packets longer than MAX_PKT_BEATS are cut with a forced tlast, and each cut is counted.
module trace_stream_arbiter #(
    parameter int NUM_SRC       = 2,
    parameter int DATA_WIDTH    = 96,
    parameter int ID_WIDTH      = 1,
    parameter int MAX_PKT_BEATS = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_enable,
    input  logic [NUM_SRC-1:0]            S_AXIS_tvalid,
    output logic [NUM_SRC-1:0]            S_AXIS_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic [NUM_SRC-1:0]            S_AXIS_tlast,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic [DATA_WIDTH-1:0]         M_AXIS_tdata,
    output logic                          M_AXIS_tlast,
    output logic [ID_WIDTH-1:0]           M_AXIS_tid,
    output logic                          pkt_truncated,
    output logic [15:0]                   truncated_count
);

    localparam int CNT_W = $clog2(MAX_PKT_BEATS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] grant, last_grant, winner;
    logic                found;
    logic [CNT_W-1:0]    beat_cnt;
    logic [NUM_SRC-1:0]  cand;
    logic                sel_last, force_last, hs, eop, trunc_evt;

    assign cand = S_AXIS_tvalid & src_enable;

    // Search begins one past the previous winner, so it only re-wins when alone.
    always_comb begin
        int unsigned idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            idx = (32'(last_grant) + i) % NUM_SRC;
            if (!found && cand[idx]) begin
                winner = ID_WIDTH'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        M_AXIS_tvalid = 1'b0;
        M_AXIS_tdata  = '0;
        M_AXIS_tid    = '0;
        sel_last      = 1'b0;
        S_AXIS_tready = '0;
        if (state == LOCKED) begin
            M_AXIS_tvalid = S_AXIS_tvalid[grant];
            M_AXIS_tdata  = S_AXIS_tdata[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
            M_AXIS_tid    = grant;
            sel_last      = S_AXIS_tlast[grant];
            for (int unsigned i = 0; i < NUM_SRC; i++)
                S_AXIS_tready[i] = (grant == ID_WIDTH'(i)) && M_AXIS_tready;
        end
    end

    assign force_last   = (state == LOCKED) && (beat_cnt == CNT_W'(MAX_PKT_BEATS-1));
    assign M_AXIS_tlast = sel_last | force_last;
    assign hs           = M_AXIS_tvalid & M_AXIS_tready;
    assign eop          = hs & M_AXIS_tlast;
    assign trunc_evt    = hs & force_last & ~sel_last;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = LOCKED;
            LOCKED:  if (eop)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            grant           <= '0;
            last_grant      <= ID_WIDTH'(NUM_SRC-1);
            beat_cnt        <= '0;
            pkt_truncated   <= 1'b0;
            truncated_count <= '0;
        end else begin
            state         <= state_nxt;
            pkt_truncated <= trunc_evt;
            if (state == IDLE && found)
                grant <= winner;
            if (hs) begin
                if (eop) begin
                    beat_cnt   <= '0;
                    last_grant <= grant;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (trunc_evt && truncated_count != 16'hFFFF)
                truncated_count <= truncated_count + 16'd1;
        end
    end

endmodule
